// File: rtl/mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// mux_scan_sequencer
//   Scan controller wrapped around an 8:1 bit mux. It steps the mux select S
//   through channels 0..7 and holds each enabled channel for DWELL cycles. On
//   the last dwell cycle it samples MUX_IN. Disabled channels are visited for
//   one cycle only and contribute a 0. The eight samples are assembled into a
//   byte. That byte is published on DATA together with a one-cycle DONE pulse.
//
// Parameters
//   DWELL    cycles S is held per enabled channel (1..15, 0 behaves as 1)
//   DWELL_W  dwell counter width, must hold DWELL-1
//
// Ports
//   CLK      clock, rising edge
//   RST      synchronous active-high reset
//   START    scan request, only looked at in IDLE
//   CH_MASK  per-channel enable, captured when a scan is launched
//   MUX_IN   mux output (combinational from S)
//   CONT     (only with MUX_SCAN_CONT_EN) relaunch straight from FIN
//   S        registered mux select
//   BUSY     high during SCAN
//   DONE     one-cycle pulse in FIN, DATA valid with it
//   DATA     assembled result, DATA[k] = MUX_IN sampled while S==k
//
// Build option
//   MUX_SCAN_CONT_EN  adds CONT for back-to-back continuous scanning
// -----------------------------------------------------------------------------
module mux_scan_sequencer #(
   parameter int DWELL   = 2,
   parameter int DWELL_W = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic [7:0] CH_MASK,
   input  logic       MUX_IN,
`ifdef MUX_SCAN_CONT_EN
   input  logic       CONT,
`endif
   output logic [2:0] S,
   output logic       BUSY,
   output logic       DONE,
   output logic [7:0] DATA
);

   localparam int                 DW_EFF  = (DWELL < 1) ? 1 : DWELL;
   localparam logic [DWELL_W-1:0] DW_LAST = DWELL_W'(DW_EFF - 1);

   typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

   state_t             state, state_nx;
   logic [2:0]         ch;
   logic [DWELL_W-1:0] cnt;
   logic [7:0]         mask_r;
   logic [7:0]         asm_r;
   logic [7:0]         asm_nx;
   logic [7:0]         data_r;
   logic [2:0]         s_r;
   logic               ch_done;
   logic               launch;
   logic               cont_w;

`ifdef MUX_SCAN_CONT_EN
   assign cont_w = CONT;
`else
   assign cont_w = 1'b0;
`endif

   // A disabled channel finishes after a single cycle. An enabled channel
   // finishes on its last dwell cycle.
   always_comb begin
      ch_done     = mask_r[ch] ? (cnt == DW_LAST) : 1'b1;
      asm_nx      = asm_r;
      asm_nx[ch]  = mask_r[ch] & MUX_IN;
      launch      = ((state == IDLE) && START) || ((state == FIN) && cont_w);
   end

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = START ? SCAN : IDLE;
         SCAN:    state_nx = (ch_done && (ch == 3'd7)) ? FIN : SCAN;
         FIN:     state_nx = cont_w ? SCAN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath. S is kept as its own register that tracks the channel to be
   // presented next cycle, so the mux select never glitches.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ch     <= 3'd0;
         cnt    <= '0;
         mask_r <= 8'h00;
         asm_r  <= 8'h00;
         data_r <= 8'h00;
         s_r    <= 3'd0;
      end else if (launch) begin
         mask_r <= CH_MASK;
         ch     <= 3'd0;
         cnt    <= '0;
         asm_r  <= 8'h00;
         s_r    <= 3'd0;
      end else if (state == SCAN) begin
         if (ch_done) begin
            asm_r <= asm_nx;
            cnt   <= '0;
            if (ch == 3'd7) begin
               // Publish together with the last sample so DATA is valid in FIN.
               data_r <= asm_nx;
               s_r    <= 3'd0;
            end else begin
               ch  <= ch + 3'd1;
               s_r <= ch + 3'd1;
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         s_r <= 3'd0;
      end
   end

   // Outputs
   always_comb begin
      S    = s_r;
      BUSY = (state == SCAN);
      DONE = (state == FIN);
      DATA = data_r;
   end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench for mux_scan_sequencer. Each launched scan pushes the
// expected per-cycle S/BUSY/DONE/DATA records, and each cycle pops one record
// and compares it.
module tb_mux_scan_sequencer;

   localparam int DW = 2;

   logic       clk = 1'b0;
   logic       rst, start, mux_in, noise, cont;
   logic [7:0] ch_mask, mux_i;
   logic [2:0] s;
   logic       busy, done;
   logic [7:0] data;

   typedef struct {
      logic [2:0] s;
      logic       busy;
      logic       done;
      logic [7:0] data;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] last_data;
   int         vecs = 0;
   int         errs = 0;

   always #5 clk = ~clk;

   assign mux_in = mux_i[s] ^ noise;

   mux_scan_sequencer #(.DWELL(DW), .DWELL_W(4)) dut (
      .CLK(clk), .RST(rst), .START(start), .CH_MASK(ch_mask), .MUX_IN(mux_in),
`ifdef MUX_SCAN_CONT_EN
      .CONT(cont),
`endif
      .S(s), .BUSY(busy), .DONE(done), .DATA(data)
   );

   // Reference model: expected cycle records for one scan starting in cycle 1.
   function automatic void push_scan(input logic [7:0] m, input logic [7:0] iv);
      exp_t e;
      for (int c = 0; c < 8; c++)
         for (int k = 0; k < (m[c] ? DW : 1); k++) begin
            e.s = 3'(c); e.busy = 1'b1; e.done = 1'b0; e.data = last_data;
            sb.push_back(e);
         end
      last_data = m & iv;
      e.s = 3'd0; e.busy = 1'b0; e.done = 1'b1; e.data = last_data;
      sb.push_back(e);
   endfunction

   function automatic void push_idle(input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.s = 3'd0; e.busy = 1'b0; e.done = 1'b0; e.data = last_data;
         sb.push_back(e);
      end
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   // START accepted at edge 0; returns #1 into cycle 1.
   task automatic launch(input logic [7:0] m);
      ch_mask = m; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1; start = 1'b1; ch_mask = 8'hFF;
      step(); step();
      rst = 1'b0; start = 1'b0;
      last_data = 8'h00;
      vecs++;
      if ({s, busy, done, data} !== 13'h0) begin
         errs++;
         $display("FAIL reset: got S=%0d BUSY=%b DONE=%b DATA=%h want all zero", s, busy, done, data);
      end
      push_idle(3);
      while (sb.size() > 0) begin
         e = sb.pop_front(); vecs++;
         if ({s, busy, done, data} !== {e.s, e.busy, e.done, e.data}) begin
            errs++;
            $display("FAIL reset_idle: got S=%0d BUSY=%b DONE=%b DATA=%h want S=%0d BUSY=%b DONE=%b DATA=%h",
                     s, busy, done, data, e.s, e.busy, e.done, e.data);
         end
         step();
      end
   endtask

   task automatic test_mask_zero();
      exp_t e;
      mux_i = 8'hFF;
      launch(8'h00);
      push_scan(8'h00, 8'hFF);
      push_idle(1);
      while (sb.size() > 0) begin
         e = sb.pop_front(); vecs++;
         if ({s, busy, done, data} !== {e.s, e.busy, e.done, e.data}) begin
            errs++;
            $display("FAIL mask_zero: got S=%0d BUSY=%b DONE=%b DATA=%h want S=%0d BUSY=%b DONE=%b DATA=%h",
                     s, busy, done, data, e.s, e.busy, e.done, e.data);
         end
         noise = ~noise;
         step();
      end
      noise = 1'b0;
   endtask

   task automatic test_partial_mask();
      exp_t e;
      mux_i = 8'hFF;
      launch(8'h0F);
      push_scan(8'h0F, 8'hFF);
      push_idle(1);
      while (sb.size() > 0) begin
         e = sb.pop_front(); vecs++;
         if ({s, busy, done, data} !== {e.s, e.busy, e.done, e.data}) begin
            errs++;
            $display("FAIL partial_mask: got S=%0d BUSY=%b DONE=%b DATA=%h want S=%0d BUSY=%b DONE=%b DATA=%h",
                     s, busy, done, data, e.s, e.busy, e.done, e.data);
         end
         step();
      end
   endtask

   // Full scan of 8'hA5 with extra START pulses in cycles 5 (SCAN) and 17 (FIN),
   // and a CH_MASK change mid-scan. None of these may affect the scan.
   task automatic test_start_ignored();
      exp_t e;
      int   cyc;
      mux_i = 8'hA5;
      launch(8'hFF);
      push_scan(8'hFF, 8'hA5);
      push_idle(3);
      cyc = 1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); vecs++;
         if ({s, busy, done, data} !== {e.s, e.busy, e.done, e.data}) begin
            errs++;
            $display("FAIL start_ignored c%0d: got S=%0d BUSY=%b DONE=%b DATA=%h want S=%0d BUSY=%b DONE=%b DATA=%h",
                     cyc, s, busy, done, data, e.s, e.busy, e.done, e.data);
         end
         start = (cyc == 5) || (cyc == 17);
         if (cyc == 3) ch_mask = 8'h00;
         step();
         cyc++;
      end
      start = 1'b0;
   endtask

   task automatic test_reset_mid_scan();
      exp_t e;
      int   cyc;
      mux_i = 8'hA5;
      launch(8'hFF);
      push_scan(8'hFF, 8'hA5);
      for (cyc = 1; cyc <= 7; cyc++) begin
         e = sb.pop_front(); vecs++;
         if ({s, busy, done, data} !== {e.s, e.busy, e.done, e.data}) begin
            errs++;
            $display("FAIL rst_mid pre c%0d: got S=%0d BUSY=%b DONE=%b DATA=%h want S=%0d BUSY=%b DONE=%b DATA=%h",
                     cyc, s, busy, done, data, e.s, e.busy, e.done, e.data);
         end
         if (cyc == 7) rst = 1'b1;
         step();
      end
      rst = 1'b0;
      sb.delete();
      last_data = 8'h00;
      push_idle(12);
      while (sb.size() > 0) begin
         e = sb.pop_front(); vecs++;
         if ({s, busy, done, data} !== {e.s, e.busy, e.done, e.data}) begin
            errs++;
            $display("FAIL rst_mid post: got S=%0d BUSY=%b DONE=%b DATA=%h want S=%0d BUSY=%b DONE=%b DATA=%h",
                     s, busy, done, data, e.s, e.busy, e.done, e.data);
         end
         step();
      end
      launch(8'hFF);
      push_scan(8'hFF, 8'hA5);
      push_idle(1);
      while (sb.size() > 0) begin
         e = sb.pop_front(); vecs++;
         if ({s, busy, done, data} !== {e.s, e.busy, e.done, e.data}) begin
            errs++;
            $display("FAIL rst_mid restart: got S=%0d BUSY=%b DONE=%b DATA=%h want S=%0d BUSY=%b DONE=%b DATA=%h",
                     s, busy, done, data, e.s, e.busy, e.done, e.data);
         end
         step();
      end
   endtask

`ifdef MUX_SCAN_CONT_EN
   task automatic test_continuous();
      exp_t e;
      int   cyc;
      mux_i = 8'h3C; cont = 1'b1;
      launch(8'hFF);
      push_scan(8'hFF, 8'h3C);
      push_scan(8'hFF, 8'hC3);
      push_idle(2);
      cyc = 1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); vecs++;
         if ({s, busy, done, data} !== {e.s, e.busy, e.done, e.data}) begin
            errs++;
            $display("FAIL continuous c%0d: got S=%0d BUSY=%b DONE=%b DATA=%h want S=%0d BUSY=%b DONE=%b DATA=%h",
                     cyc, s, busy, done, data, e.s, e.busy, e.done, e.data);
         end
         if (cyc == 17) mux_i = 8'hC3;
         if (cyc == 18) cont = 1'b0;
         step();
         cyc++;
      end
   endtask
`endif

   initial begin
      rst = 1'b1; start = 1'b0; ch_mask = 8'h00; mux_i = 8'h00;
      noise = 1'b0; cont = 1'b0; last_data = 8'h00;
      #2;
      test_reset();
      test_mask_zero();
      test_partial_mask();
      test_start_ignored();
      test_reset_mid_scan();
`ifdef MUX_SCAN_CONT_EN
      test_continuous();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
